// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus definitions for the SRAM responder: bus widths, responder
// state encoding and the word-address range helper.
package dbus_sram_responder_pkg;

    localparam int DBUS_ADDR_W      = 64;
    localparam int DBUS_DATA_W      = 64;
    localparam int DBUS_STRB_W      = 8;
    localparam int DBUS_BYTE_OFS_W  = 3;
    localparam int DBUS_WORD_ADDR_W = DBUS_ADDR_W - DBUS_BYTE_OFS_W;
    localparam int DBUS_LAT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_rsp_state_e;

    // A word address is served only when it lies inside the physical array.
    function automatic logic word_in_range(
        input logic [DBUS_WORD_ADDR_W-1:0] word,
        input logic [31:0]                 depth
    );
        return (word < {29'd0, depth});
    endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response channel between the memory-stage initiator
// (master) and the SRAM responder (slave).
interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [DBUS_ADDR_W-1:0] req_addr;
    logic                   req_we;
    logic [DBUS_STRB_W-1:0] req_wstrb;
    logic [DBUS_DATA_W-1:0] req_wdata;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DBUS_DATA_W-1:0] resp_rdata;
    logic                   resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wstrb, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wstrb, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dbus_sram_responder_sram_word_array.sv
// Single-port byte-writable word array with a registered read port; written
// in the shape block-RAM inference expects (no reset on storage or rdata).
module sram_word_array
    import dbus_sram_responder_pkg::*;
#(
    parameter  int DEPTH_WORDS = 4096,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   clock,
    input  logic                   en,
    input  logic                   we,
    input  logic [DBUS_STRB_W-1:0] be,
    input  logic [IDX_W-1:0]       idx,
    input  logic [DBUS_DATA_W-1:0] wdata,
    output logic [DBUS_DATA_W-1:0] rdata
);

    logic [DBUS_DATA_W-1:0] mem_r [DEPTH_WORDS];

    // One access per enabled edge: strobed byte lanes on write, word capture on read.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DBUS_STRB_W; b++) begin
                    if (be[b]) begin
                        mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem_r[idx];
            end
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM target: one outstanding request, programmable wait cycles,
// byte-strobed access to a local word array and a held response with range error.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    dbus_sram_responder_if.slave  bus
);

    localparam int                    IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [DBUS_LAT_W-1:0] LAT_CNT = DBUS_LAT_W'(LATENCY);
    localparam logic [31:0]           DEPTH_V = 32'(DEPTH_WORDS);

    dbus_rsp_state_e              state_r;
    logic [DBUS_LAT_W-1:0]        cnt_r;
    logic [DBUS_WORD_ADDR_W-1:0]  addr_r;
    logic                         we_r;
    logic [DBUS_STRB_W-1:0]       wstrb_r;
    logic [DBUS_DATA_W-1:0]       wdata_r;
    logic                         err_r;
    logic                         rdata_zero_r;

    logic                         accept_s;
    logic                         access_s;
    logic                         in_range_s;
    logic                         sram_en_s;
    logic [DBUS_WORD_ADDR_W-1:0]  acc_word_s;
    logic                         acc_we_s;
    logic [DBUS_STRB_W-1:0]       acc_strb_s;
    logic [DBUS_DATA_W-1:0]       acc_wdata_s;
    logic [DBUS_DATA_W-1:0]       sram_rdata_s;
    logic                         unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^bus.req_addr[DBUS_BYTE_OFS_W-1:0];
    assign accept_s          = (state_r == IDLE) && bus.req_valid;

    // Zero-latency builds hit the array on the accept edge straight from the bus;
    // otherwise the latched request is used on the last wait edge.
    always_comb begin
        acc_word_s  = addr_r;
        acc_we_s    = we_r;
        acc_strb_s  = wstrb_r;
        acc_wdata_s = wdata_r;
        access_s    = 1'b0;
        if (LATENCY == 0) begin
            acc_word_s  = bus.req_addr[DBUS_ADDR_W-1:DBUS_BYTE_OFS_W];
            acc_we_s    = bus.req_we;
            acc_strb_s  = bus.req_wstrb;
            acc_wdata_s = bus.req_wdata;
            access_s    = accept_s;
        end else begin
            access_s    = (state_r == WAIT) && (cnt_r == 4'd1);
        end
    end

    assign in_range_s = word_in_range(acc_word_s, DEPTH_V);
    // Reset gating keeps a zero-latency request presented during reset from writing.
    assign sram_en_s  = access_s && in_range_s && !reset;

    sram_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clock (clock),
        .en    (sram_en_s),
        .we    (acc_we_s),
        .be    (acc_strb_s),
        .idx   (acc_word_s[IDX_W-1:0]),
        .wdata (acc_wdata_s),
        .rdata (sram_rdata_s)
    );

    // Request latch, wait counter and response flags, sequenced by the responder state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            addr_r       <= 61'd0;
            we_r         <= 1'b0;
            wstrb_r      <= 8'd0;
            wdata_r      <= 64'd0;
            err_r        <= 1'b0;
            rdata_zero_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r  <= bus.req_addr[DBUS_ADDR_W-1:DBUS_BYTE_OFS_W];
                        we_r    <= bus.req_we;
                        wstrb_r <= bus.req_wstrb;
                        wdata_r <= bus.req_wdata;
                        if (access_s) begin
                            state_r      <= RESP;
                            err_r        <= !in_range_s;
                            rdata_zero_r <= acc_we_s || !in_range_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= LAT_CNT;
                        end
                    end
                end
                WAIT: begin
                    if (access_s) begin
                        state_r      <= RESP;
                        cnt_r        <= 4'd0;
                        err_r        <= !in_range_s;
                        rdata_zero_r <= acc_we_s || !in_range_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_r      <= IDLE;
                        err_r        <= 1'b0;
                        rdata_zero_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // The array's read register only refreshes on reads, so writes and errors mask it.
    assign bus.req_ready  = (state_r == IDLE);
    assign bus.resp_valid = (state_r == RESP);
    assign bus.resp_err   = err_r;
    assign bus.resp_rdata = rdata_zero_r ? 64'd0 : sram_rdata_s;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: three instances (LATENCY 0/2/3, 16 words)
// driven through one shared stimulus path and checked against a word-array model.
module tb_dbus_sram_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          sel   = 0;
    logic        req_valid_s  = 1'b0;
    logic        req_we_s     = 1'b0;
    logic        resp_ready_s = 1'b0;
    logic [63:0] req_addr_s   = 64'd0;
    logic [63:0] req_wdata_s  = 64'd0;
    logic [7:0]  req_wstrb_s  = 8'd0;

    logic        obs_req_ready  [NDUT];
    logic        obs_resp_valid [NDUT];
    logic        obs_resp_err   [NDUT];
    logic [63:0] obs_resp_rdata [NDUT];
    int          obs_acc        [NDUT];
    int          obs_hs         [NDUT];

    int          total = 0;
    int          bad   = 0;
    int          exp_acc [NDUT];
    int          exp_hs  [NDUT];
    logic [63:0] model_mem [NDUT][DEPTH];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        int acc_n = 0;
        int hs_n  = 0;
        dbus_sram_responder_if bus ();

        assign bus.req_valid  = req_valid_s && (sel == g);
        assign bus.req_addr   = req_addr_s;
        assign bus.req_we     = req_we_s;
        assign bus.req_wstrb  = req_wstrb_s;
        assign bus.req_wdata  = req_wdata_s;
        assign bus.resp_ready = resp_ready_s && (sel == g);

        assign obs_req_ready[g]  = bus.req_ready;
        assign obs_resp_valid[g] = bus.resp_valid;
        assign obs_resp_err[g]   = bus.resp_err;
        assign obs_resp_rdata[g] = bus.resp_rdata;
        assign obs_acc[g]        = acc_n;
        assign obs_hs[g]         = hs_n;

        always @(posedge clock) begin
            if (bus.req_valid && bus.req_ready) acc_n <= acc_n + 1;
            if (bus.resp_valid && bus.resp_ready) hs_n <= hs_n + 1;
        end

        dbus_sram_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (LAT)
        ) u_dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );
    end

    function automatic int lat_of(input int s);
        case (s)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge; leaves the bench in the first cycle after accept.
    task automatic send_req(input int s, input logic [63:0] addr, input logic we,
                            input logic [7:0] strb, input logic [63:0] data, input bit hold);
        int n = 0;
        sel = s;
        req_addr_s = addr; req_we_s = we; req_wstrb_s = strb; req_wdata_s = data;
        req_valid_s = 1'b1;
        while (!obs_req_ready[s] && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_val("accept", 64'(obs_req_ready[s]), 64'd1);
        @(posedge clock);
        @(negedge clock);
        exp_acc[s]++;
        if (!hold) req_valid_s = 1'b0;
    endtask

    task automatic get_resp(input int s, input int stall, output logic [63:0] rd,
                            output logic er, output int k);
        k = 1;
        while (!obs_resp_valid[s] && k < 60) begin
            check_val("ready_in_wait", 64'(obs_req_ready[s]), 64'd0);
            @(negedge clock);
            k++;
        end
        check_val("resp_valid", 64'(obs_resp_valid[s]), 64'd1);
        rd = obs_resp_rdata[s];
        er = obs_resp_err[s];
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check_val("hold_rdata", obs_resp_rdata[s], rd);
            check_val("hold_err", 64'(obs_resp_err[s]), 64'(er));
            check_val("hold_valid", 64'(obs_resp_valid[s]), 64'd1);
            check_val("ready_in_resp", 64'(obs_req_ready[s]), 64'd0);
        end
        resp_ready_s = 1'b1;
        @(posedge clock);
        #1 resp_ready_s = 1'b0;
        exp_hs[s]++;
        @(negedge clock);
        check_val("ready_after_hs", 64'(obs_req_ready[s]), 64'd1);
        check_val("valid_after_hs", 64'(obs_resp_valid[s]), 64'd0);
    endtask

    task automatic expect_resp(input int s, input logic [63:0] addr, input logic we,
                               input logic [7:0] strb, input logic [63:0] data,
                               input logic [63:0] rd, input logic er, input int k);
        logic        in_range;
        int          idx;
        logic [63:0] w;
        logic [63:0] exp_rd;
        in_range = (addr >> 3) < 64'(DEPTH);
        idx      = int'((addr >> 3) % 64'(DEPTH));
        exp_rd   = (we || !in_range) ? 64'd0 : model_mem[s][idx];
        if (we && in_range) begin
            w = model_mem[s][idx];
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
            end
            model_mem[s][idx] = w;
        end
        check_val("resp_err", 64'(er), 64'(!in_range));
        check_val("resp_rdata", rd, exp_rd);
        check_val("latency", 64'(k), 64'(lat_of(s) + 1));
    endtask

    task automatic txn(input int s, input logic [63:0] addr, input logic we,
                       input logic [7:0] strb, input logic [63:0] data, input int stall,
                       output logic [63:0] rd);
        logic er;
        int   k;
        send_req(s, addr, we, strb, data, 1'b0);
        get_resp(s, stall, rd, er, k);
        expect_resp(s, addr, we, strb, data, rd, er, k);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          k;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        we;
        int          s;
        int          stall;

        for (int i = 0; i < NDUT; i++) begin
            exp_acc[i] = 0;
            exp_hs[i]  = 0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < NDUT; i++) begin
            check_val("rst_req_ready", 64'(obs_req_ready[i]), 64'd1);
            check_val("rst_resp_valid", 64'(obs_resp_valid[i]), 64'd0);
            check_val("rst_resp_rdata", obs_resp_rdata[i], 64'd0);
            check_val("rst_resp_err", 64'(obs_resp_err[i]), 64'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        // Known contents everywhere so every later read has a defined expectation.
        for (int i = 0; i < NDUT; i++) begin
            for (int w = 0; w < DEPTH; w++) begin
                txn(i, 64'(w * 8), 1'b1, 8'hFF, {$urandom, $urandom}, 0, rd);
            end
        end

        for (int i = 0; i < 2; i++) begin
            txn(i, 64'h40, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, 0, rd);
            txn(i, 64'h40, 1'b0, 8'h00, 64'd0, 0, rd);
            check_val("lat_readback", rd, 64'h1122_3344_5566_7788);
        end

        txn(1, 64'h8, 1'b1, 8'hFF, 64'd0, 0, rd);
        txn(1, 64'h8, 1'b1, 8'b1000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd);
        txn(1, 64'h8, 1'b0, 8'h00, 64'd0, 0, rd);
        check_val("strobe_merge", rd, 64'hFF00_0000_0000_00FF);
        txn(1, 64'h8, 1'b1, 8'h00, 64'hABCD_ABCD_ABCD_ABCD, 0, rd);
        txn(1, 64'h8, 1'b0, 8'h00, 64'd0, 0, rd);
        check_val("zero_strobe", rd, 64'hFF00_0000_0000_00FF);

        txn(0, 64'h80, 1'b0, 8'h00, 64'd0, 0, rd);
        txn(0, 64'h1000, 1'b1, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, 0, rd);
        txn(0, 64'h1000, 1'b0, 8'h00, 64'd0, 0, rd);
        for (int w = 0; w < DEPTH; w++) begin
            txn(0, 64'(w * 8), 1'b0, 8'h00, 64'd0, 0, rd);
        end

        // Second request waits on the bus for the whole stalled response.
        send_req(1, 64'h40, 1'b0, 8'h00, 64'd0, 1'b1);
        req_addr_s = 64'h8;
        get_resp(1, 5, rd, er, k);
        expect_resp(1, 64'h40, 1'b0, 8'h00, 64'd0, rd, er, k);
        @(posedge clock);
        @(negedge clock);
        exp_acc[1]++;
        check_val("bp_second_taken", 64'(obs_req_ready[1]), 64'd0);
        req_valid_s = 1'b0;
        get_resp(1, 0, rd, er, k);
        expect_resp(1, 64'h8, 1'b0, 8'h00, 64'd0, rd, er, k);

        // Reset two cycles after accepting a write that is still waiting.
        send_req(2, 64'h20, 1'b1, 8'hFF, 64'h0000_0000_DEAD_BEEF, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("rst_mid_ready", 64'(obs_req_ready[2]), 64'd1);
        check_val("rst_mid_valid", 64'(obs_resp_valid[2]), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check_val("post_rst_ready", 64'(obs_req_ready[2]), 64'd1);
        check_val("post_rst_valid", 64'(obs_resp_valid[2]), 64'd0);
        txn(2, 64'h20, 1'b0, 8'h00, 64'd0, 0, rd);

        for (int n = 0; n < 2000; n++) begin
            s  = int'($urandom_range(0, 2));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                addr = {$urandom, $urandom};
                if ((addr >> 3) < 64'(DEPTH)) addr[20] = 1'b1;
            end else begin
                addr = 64'($urandom_range(0, 127));
            end
            strb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            data  = {$urandom, $urandom};
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            txn(s, addr, we, strb, data, stall, rd);
        end

        for (int i = 0; i < NDUT; i++) begin
            check_val("accept_count", 64'(obs_acc[i]), 64'(exp_acc[i]));
            check_val("handshake_count", 64'(obs_hs[i]), 64'(exp_hs[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Single-ported SRAM responder that serves the core's data-memory request channel, acting as the target that the memory stage's data-bus initiator talks to. It accepts one request at a time through a valid/ready handshake, applies a configurable number of wait cycles, performs a byte-strobed read or write on an internal word array, and returns a held response with an error flag for out-of-range addresses. Instances sit beside the core in simulation tops and in FPGA builds as tightly coupled data RAM.

## Interface
Parameters:
- `DEPTH_WORDS`, default 4096: number of 64-bit words; power of two, at least 2.
- `LATENCY`, default 1: wait cycles inserted between request accept and array access; range 0..15.

Ports. Clocking is decided: one clock; reset is asynchronous and active-high.
- `clock`  in  1: sole clock; rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request.
- `req_addr`  in  64: byte address; bits [2:0] ignored.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_wstrb`  in  8: byte enables for writes; bit i covers data[8i+7:8i].
- `req_wdata`  in  64: write data.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: initiator takes the response.
- `resp_rdata`  out  64: read data; 0 for writes and errors.
- `resp_err`  out  1: address out of range.

## Operation
- FSM with states IDLE, WAIT, RESP; reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch addr, we, wstrb and wdata.
  - Go to WAIT with counter = `LATENCY` when `LATENCY` > 0.
  - When `LATENCY` = 0, access the array on the accept edge and go to RESP.
- WAIT:
  - `req_ready` = 0 and the counter decrements each cycle.
  - On the edge where the counter reaches 1, access the array and go to RESP.
- Array access happens on one edge only:
  - Index = latched addr[3+log2(DEPTH_WORDS)-1:3].
  - Out of range when latched addr[63:3] >= `DEPTH_WORDS`: `resp_err` = 1, no write, `resp_rdata` = 0.
  - Write: only the strobed bytes are updated; `resp_rdata` = 0.
  - Write with `req_wstrb` = 0: no change, normal response.
  - Read: `resp_rdata` = word contents after all earlier writes (read-after-write coherent).
- RESP:
  - `resp_valid` = 1, and `resp_rdata`/`resp_err` hold stable until `resp_valid && resp_ready`.
  - On that handshake go to IDLE.
- Exactly one transaction is outstanding at a time. A new request is never accepted in the response-handshake cycle.
- Reset mid-operation:
  - Any transaction in IDLE-accept or WAIT is dropped; a write in WAIT is not committed.
  - A write already committed (now in RESP) stays committed.
  - Array contents are not cleared by reset; they are undefined at power-up.

## Timing
- Reset values: `req_ready` = 1 (IDLE), `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0; counter = 0.
- Accept edge T: `resp_valid` rises after edge T+LATENCY and is visible in cycle T+LATENCY+1.
- `req_ready` rises the cycle after the response handshake.
- Minimum period per transaction is LATENCY+2 cycles with `resp_ready` tied high.
- All outputs are registered or derived from state only. There are no combinational paths from `req_*` or `resp_ready` to any output.

## Structure
- Shared package/header (alongside the bus definitions): `DBUS_DATA_W` = 64, `DBUS_STRB_W` = 8, and the state enum `dbus_rsp_state_e` {IDLE, WAIT, RESP}.
- Sub-module `sram_word_array`:
  - `DEPTH_WORDS` x 64-bit.
  - Synchronous port: en, we, 8-bit byte-enable, index, wdata, registered rdata.
  - Behavioural model; maps to block RAM.
- Top level holds the FSM, latency counter, request latch, range check and response register.

## Test plan
- Reset mid-WAIT: `LATENCY`=3, issue write 0xDEAD_BEEF to 0x20, assert `reset` two cycles after accept, then read 0x20. Required: `resp_rdata` differs from 0xDEAD_BEEF only if it was preloaded, and the array was not written by the aborted request; after reset `req_ready` = 1 and `resp_valid` = 0.
- Latency: `LATENCY`=0 and `LATENCY`=2, write 0x1122_3344_5566_7788 to 0x40 then read 0x40. Required: `resp_valid` visible 1 and 3 cycles after accept respectively, read returns 0x1122_3344_5566_7788, `resp_err` = 0.
- Byte strobes: preload 0 at 0x8, write 0xFFFF_FFFF_FFFF_FFFF with `req_wstrb` = 8'b1000_0001, then read. Required: 0xFF00_0000_0000_00FF.
- Out of range: `DEPTH_WORDS`=16, read 0x80, then write 0x1000 and read 0x1000. Required: `resp_err` = 1 with `resp_rdata` = 0 for each, and no in-range word altered.
- Backpressure: `resp_ready` low for 5 cycles while `req_valid` stays high with a second request. Required: response fields are stable, `req_ready` = 0 throughout, and the second request is accepted exactly 1 cycle after the handshake.
- Random check: 2000 back-to-back random reads and writes with random stalls against a reference memory model. Required: zero mismatches and no request lost or duplicated.
